// File: rtl/dac_seg_pkg.sv
// Shared defaults and helper functions for the segmented DAC encoder.
package dac_seg_pkg;

   localparam int unsigned N_BIN_DEF = 7;
   localparam int unsigned N_MSB_DEF = 4;
   // Widest thermometer word the mask helper can build (N_MSB up to 6).
   localparam int unsigned THERM_MAX = 64;

   // Unary vector of k set cells starting at cell ptr, wrapping modulo n.
   function automatic logic [THERM_MAX-1:0] therm_mask(input int unsigned k,
                                                       input int unsigned ptr,
                                                       input int unsigned n);
      logic [THERM_MAX-1:0] m;
      int unsigned          off;
      m = '0;
      for (int unsigned i = 0; i < THERM_MAX; i++) begin
         off = (i >= ptr) ? (i - ptr) : (i + n - ptr);
         if ((i < n) && (off < k)) begin
            m = m | (THERM_MAX'(1) << i);
         end
      end
      return m;
   endfunction

   // (ptr + k) mod n, valid because ptr < n and k <= n.
   function automatic int unsigned wrap_add(input int unsigned ptr,
                                            input int unsigned k,
                                            input int unsigned n);
      int unsigned s;
      s = ptr + k;
      if (s >= n) begin
         s = s - n;
      end
      return s;
   endfunction

endpackage

// File: rtl/dac_dwa_rotator.sv
// DWA start pointer register and combinational rotated thermometer mask.
module dac_dwa_rotator
   import dac_seg_pkg::*;
#(
   parameter int unsigned N_THERM = 15,
   parameter int unsigned PTR_W   = 4,
   parameter int unsigned K_W     = 4
) (
   input  logic               clkin,
   input  logic               rstb,
   input  logic               clr,
   input  logic               adv,
   input  logic               dwa_en,
   input  logic [K_W-1:0]     k,
   output logic [PTR_W-1:0]   ptr,
   output logic [N_THERM-1:0] mask_c
);

   logic [PTR_W-1:0] start_c;

   // Static mode always fills from cell 0; DWA mode fills from the pointer.
   always_comb begin
      start_c = dwa_en ? ptr : '0;
      mask_c  = N_THERM'(therm_mask(32'(k), 32'(start_c), N_THERM));
   end

   // Pointer advances by k on each sample leaving the pipe; static mode pins it to 0.
   always_ff @(posedge clkin or negedge rstb) begin
      if (!rstb) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= dwa_en ? PTR_W'(wrap_add(32'(ptr), 32'(k), N_THERM)) : '0;
      end
   end

endmodule

// File: rtl/dac_seg_encoder.sv
// Segmented DAC front-end: format conversion, 2-stage pipe, binary/thermometer output flops.
module dac_seg_encoder
   import dac_seg_pkg::*;
#(
   parameter  int unsigned N_BIN   = N_BIN_DEF,
   parameter  int unsigned N_MSB   = N_MSB_DEF,
   localparam int unsigned N_THERM = 2**N_MSB - 1,
   localparam int unsigned PTR_W   = $clog2(N_THERM)
) (
   input  logic                   clkin,
   input  logic                   rstb,
   input  logic                   pdb,
   input  logic [N_BIN+N_MSB-1:0] data_in,
   input  logic                   data_valid,
   input  logic                   fmt_twos,
   input  logic                   dwa_en,
   output logic [N_BIN-1:0]       datainbin,
   output logic [N_BIN-1:0]       datainbinb,
   output logic [N_THERM-1:0]     dataintherm,
   output logic [N_THERM-1:0]     datainthermb,
   output logic                   out_valid,
   output logic [PTR_W-1:0]       dwa_ptr
);

   localparam int unsigned N_CODE = N_BIN + N_MSB;

   logic [N_CODE-1:0]  code_c;
   logic               s1_valid;
   logic [N_MSB-1:0]   s1_k;
   logic [N_BIN-1:0]   s1_b;
   logic               s2_valid;
   logic [N_MSB-1:0]   s2_k;
   logic [N_BIN-1:0]   s2_b;
   logic [N_THERM-1:0] mask_c;

   // Two's complement to offset binary is an MSB flip.
   always_comb begin
      code_c = fmt_twos ? {~data_in[N_CODE-1], data_in[N_CODE-2:0]} : data_in;
   end

   // Stage 1 splits the code; stage 2 lines the sample up with the pointer update.
   always_ff @(posedge clkin or negedge rstb) begin
      if (!rstb) begin
         s1_valid <= 1'b0;
         s1_k     <= '0;
         s1_b     <= '0;
         s2_valid <= 1'b0;
         s2_k     <= '0;
         s2_b     <= '0;
      end else begin
         s1_valid <= pdb & data_valid;
         s2_valid <= pdb & s1_valid;
         if (data_valid) begin
            s1_k <= code_c[N_CODE-1:N_BIN];
            s1_b <= code_c[N_BIN-1:0];
         end
         if (s1_valid) begin
            s2_k <= s1_k;
            s2_b <= s1_b;
         end
      end
   end

   dac_dwa_rotator #(
      .N_THERM (N_THERM),
      .PTR_W   (PTR_W),
      .K_W     (N_MSB)
   ) u_rot (
      .clkin   (clkin),
      .rstb    (rstb),
      .clr     (~pdb),
      .adv     (s2_valid),
      .dwa_en  (dwa_en),
      .k       (s2_k),
      .ptr     (dwa_ptr),
      .mask_c  (mask_c)
   );

   // True and complement buses share one flop stage so they never skew.
   always_ff @(posedge clkin or negedge rstb) begin
      if (!rstb) begin
         datainbin    <= '0;
         datainbinb   <= '1;
         dataintherm  <= '0;
         datainthermb <= '1;
         out_valid    <= 1'b0;
      end else if (!pdb) begin
         datainbin    <= '0;
         datainbinb   <= '1;
         dataintherm  <= '0;
         datainthermb <= '1;
         out_valid    <= 1'b0;
      end else if (s2_valid) begin
         datainbin    <= s2_b;
         datainbinb   <= ~s2_b;
         dataintherm  <= mask_c;
         datainthermb <= ~mask_c;
         out_valid    <= 1'b1;
      end else begin
         out_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dac_seg_encoder.sv
// Self-checking bench for dac_seg_encoder with a cycle-level behavioural model.
module tb_dac_seg_encoder;

   logic        clkin = 1'b0;
   logic        rstb;
   logic        pdb;
   logic [10:0] data_in;
   logic        data_valid;
   logic        fmt_twos;
   logic        dwa_en;
   logic [6:0]  datainbin;
   logic [6:0]  datainbinb;
   logic [14:0] dataintherm;
   logic [14:0] datainthermb;
   logic        out_valid;
   logic [3:0]  dwa_ptr;

   int total = 0;
   int bad   = 0;

   // Model state: two in-flight slots (index 1 is the older) and expected outputs.
   logic        p_v [2];
   int          p_k [2];
   int          p_b [2];
   logic        e_ov;
   logic [6:0]  e_bin;
   logic [14:0] e_therm;
   int          e_ptr;
   logic [48:0] rst_vec;

   always #5 clkin = ~clkin;

   dac_seg_encoder dut (
      .clkin        (clkin),
      .rstb         (rstb),
      .pdb          (pdb),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .fmt_twos     (fmt_twos),
      .dwa_en       (dwa_en),
      .datainbin    (datainbin),
      .datainbinb   (datainbinb),
      .dataintherm  (dataintherm),
      .datainthermb (datainthermb),
      .out_valid    (out_valid),
      .dwa_ptr      (dwa_ptr)
   );

   function automatic logic [48:0] obs();
      return {out_valid, datainbin, datainbinb, dataintherm, datainthermb, dwa_ptr};
   endfunction

   function automatic logic [48:0] expv();
      return {e_ov, e_bin, ~e_bin, e_therm, ~e_therm, 4'(e_ptr)};
   endfunction

   task automatic model_reset();
      p_v[0] = 1'b0; p_v[1] = 1'b0;
      p_k[0] = 0;    p_k[1] = 0;
      p_b[0] = 0;    p_b[1] = 0;
      e_ov = 1'b0; e_bin = '0; e_therm = '0; e_ptr = 0;
   endtask

   // What the encoder should do at the coming rising edge, given current inputs.
   task automatic model_edge();
      int code;
      if (!pdb) begin
         model_reset();
      end else begin
         if (p_v[1]) begin
            e_bin   = 7'(p_b[1]);
            e_therm = '0;
            if (dwa_en) begin
               for (int j = 0; j < p_k[1]; j++) begin
                  e_therm = e_therm | (15'(1) << ((e_ptr + j) % 15));
               end
               e_ptr = (e_ptr + p_k[1]) % 15;
            end else begin
               e_therm = 15'((1 << p_k[1]) - 1);
               e_ptr   = 0;
            end
            e_ov = 1'b1;
         end else begin
            e_ov = 1'b0;
         end
         p_v[1] = p_v[0]; p_k[1] = p_k[0]; p_b[1] = p_b[0];
         code   = fmt_twos ? ((int'(data_in) + 1024) % 2048) : int'(data_in);
         p_v[0] = data_valid;
         p_k[0] = code / 128;
         p_b[0] = code % 128;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clkin);
      #1;
   endtask

   task automatic test_reset();
      rstb = 1'b0; pdb = 1'b1; data_in = '0; data_valid = 1'b0;
      fmt_twos = 1'b0; dwa_en = 1'b0;
      model_reset();
      #12;
      total++;
      if (obs() !== rst_vec) begin
         bad++; $display("FAIL reset_state got=%h exp=%h", obs(), rst_vec);
      end
      @(negedge clkin); rstb = 1'b1;
      @(posedge clkin); #1;
      // Stream samples, then hit reset with two still in flight.
      dwa_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_valid = 1'b1; data_in = 11'($urandom);
         tick();
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL reset_prestream cyc=%0d got=%h exp=%h", i, obs(), expv());
         end
      end
      #2 rstb = 1'b0;
      model_reset();
      #1;
      total++;
      if (obs() !== rst_vec) begin
         bad++; $display("FAIL reset_async got=%h exp=%h", obs(), rst_vec);
      end
      data_valid = 1'b0;
      #1 rstb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL reset_flush cyc=%0d got=%h exp=%h", i, obs(), expv());
         end
      end
      data_valid = 1'b1; data_in = 11'($urandom);
      tick();
      data_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_lat1 got=%b exp=0", out_valid);
      end
      tick();
      total++;
      if (obs() !== expv() || out_valid !== 1'b1) begin
         bad++; $display("FAIL reset_first_sample got=%h exp=%h", obs(), expv());
      end
   endtask

   task automatic test_static();
      dwa_en = 1'b0; fmt_twos = 1'b0;
      data_valid = 1'b1; data_in = 11'h5A3;
      tick();
      data_valid = 1'b0;
      tick();
      tick();
      total++;
      if (dataintherm !== 15'h07FF || datainthermb !== 15'h7800 ||
          datainbin !== 7'd35 || datainbinb !== 7'd92 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL static_5a3 got th=%h thb=%h bin=%0d binb=%0d ov=%b exp 07ff 7800 35 92 1",
                  dataintherm, datainthermb, datainbin, datainbinb, out_valid);
      end
      for (int i = 0; i < 20; i++) begin
         data_valid = 1'b1; data_in = 11'($urandom); fmt_twos = 1'($urandom);
         tick();
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL static_rand cyc=%0d got=%h exp=%h", i, obs(), expv());
         end
      end
      data_valid = 1'b0;
      tick(); tick();
      fmt_twos = 1'b0;
   endtask

   task automatic test_dwa_wrap();
      logic [3:0] kv [4];
      logic [14:0] th [4];
      logic [3:0] pv [4];
      kv[0] = 4'd10; kv[1] = 4'd10; kv[2] = 4'd15; kv[3] = 4'd0;
      th[0] = 15'h03FF; th[1] = 15'h7C1F; th[2] = 15'h7FFF; th[3] = 15'h0000;
      pv[0] = 4'd10; pv[1] = 4'd5; pv[2] = 4'd5; pv[3] = 4'd5;
      dwa_en = 1'b1; fmt_twos = 1'b0;
      for (int i = 0; i < 6; i++) begin
         data_valid = (i < 4);
         data_in    = {kv[i % 4], 7'($urandom)};
         tick();
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL dwa_model cyc=%0d got=%h exp=%h", i, obs(), expv());
         end
         if (i >= 2) begin
            total++;
            if (dataintherm !== th[i-2] || dwa_ptr !== pv[i-2] || out_valid !== 1'b1) begin
               bad++;
               $display("FAIL dwa_wrap s%0d got th=%h ptr=%0d ov=%b exp th=%h ptr=%0d",
                        i - 2, dataintherm, dwa_ptr, out_valid, th[i-2], pv[i-2]);
            end
         end
      end
      data_valid = 1'b0;
   endtask

   task automatic test_dwa_toggle();
      // Pointer is 5 here; static sample zeroes it, re-enabled DWA starts from 0.
      dwa_en = 1'b0; data_valid = 1'b1; data_in = {4'd3, 7'd1};
      tick(); data_valid = 1'b0; tick(); tick();
      total++;
      if (dataintherm !== 15'h0007 || dwa_ptr !== 4'd0) begin
         bad++; $display("FAIL dwa_off got th=%h ptr=%0d exp th=0007 ptr=0", dataintherm, dwa_ptr);
      end
      dwa_en = 1'b1; data_valid = 1'b1; data_in = {4'd4, 7'd2};
      tick(); data_valid = 1'b0; tick(); tick();
      total++;
      if (dataintherm !== 15'h000F || dwa_ptr !== 4'd4 || obs() !== expv()) begin
         bad++; $display("FAIL dwa_on got th=%h ptr=%0d exp th=000f ptr=4", dataintherm, dwa_ptr);
      end
   endtask

   task automatic test_twos();
      dwa_en = 1'b0; fmt_twos = 1'b1;
      data_valid = 1'b1; data_in = 11'h000;
      tick();
      data_in = 11'h400;
      tick();
      data_valid = 1'b0;
      tick();
      total++;
      if (dataintherm !== 15'h00FF || datainbin !== 7'd0 || out_valid !== 1'b1) begin
         bad++; $display("FAIL twos_zero got th=%h bin=%0d ov=%b exp th=00ff bin=0 ov=1",
                         dataintherm, datainbin, out_valid);
      end
      tick();
      total++;
      if (dataintherm !== 15'h0000 || datainbin !== 7'd0 || datainthermb !== 15'h7FFF) begin
         bad++; $display("FAIL twos_min got th=%h thb=%h bin=%0d exp th=0000 thb=7fff bin=0",
                         dataintherm, datainthermb, datainbin);
      end
      fmt_twos = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      for (int m = 0; m < 2; m++) begin
         dwa_en = (m == 0);
         for (int i = 0; i < 60; i++) begin
            data_valid = ($urandom_range(3) != 0);
            data_in    = 11'($urandom);
            fmt_twos   = 1'($urandom);
            tick();
            total++;
            if (obs() !== expv()) begin
               bad++; $display("FAIL b2b mode=%0d cyc=%0d got=%h exp=%h", m, i, obs(), expv());
            end
         end
         data_valid = 1'b0;
         tick(); tick();
      end
      fmt_twos = 1'b0;
   endtask

   task automatic test_power_down();
      dwa_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_valid = 1'b1; data_in = 11'($urandom);
         tick();
         total++;
         if (obs() !== expv()) begin
            bad++; $display("FAIL pd_pre cyc=%0d got=%h exp=%h", i, obs(), expv());
         end
      end
      pdb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_in = 11'($urandom);
         tick();
         total++;
         if (obs() !== rst_vec || obs() !== expv()) begin
            bad++; $display("FAIL pd_parked cyc=%0d got=%h exp=%h", i, obs(), rst_vec);
         end
      end
      pdb = 1'b1;
      for (int s = 0; s < 4; s++) begin
         data_valid = 1'b1; data_in = 11'($urandom);
         for (int g = 0; g < 5; g++) begin
            tick();
            data_valid = 1'b0;
            total++;
            if (obs() !== expv()) begin
               bad++; $display("FAIL pd_hold s=%0d g=%0d got=%h exp=%h", s, g, obs(), expv());
            end
         end
      end
   endtask

   initial begin
      rst_vec = {1'b0, 7'd0, 7'h7F, 15'd0, 15'h7FFF, 4'd0};
      test_reset();
      test_static();
      test_dwa_wrap();
      test_dwa_toggle();
      test_twos();
      test_back_to_back();
      test_power_down();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dac_seg_encoder.md
Name: dac_seg_encoder

Overview:
Synthesisable digital front-end for the segmented current-steering DAC core. It takes one N_BIN+N_MSB-bit sample code per valid cycle and splits it into a binary LSB word and a thermometer MSB word. The thermometer word is either static or rotated by data-weighted averaging (DWA). Registered true and complement buses drive the core's datainbin/datainbinb/dataintherm/datainthermb pins directly, clocked by clkin.

Parameters:
N_BIN, 7, binary LSB bits passed straight to the binary array
N_MSB, 4, MSB bits converted to thermometer
N_THERM, 2**N_MSB-1 (localparam, 15 by default), number of unary MSB cells
PTR_W, $clog2(N_THERM) (localparam), DWA pointer width

Ports:
clkin  in  1  sample clock; all flops on the rising edge
rstb  in  1  asynchronous active-low reset
pdb  in  1  power-down bar, synchronous; 0 parks the outputs
data_in  in  N_BIN+N_MSB  sample code
data_valid  in  1  data_in is a new sample this cycle
fmt_twos  in  1  1 = data_in is two's complement, 0 = offset binary (static config)
dwa_en  in  1  1 = DWA rotation, 0 = static thermometer
datainbin  out  N_BIN  binary LSB word
datainbinb  out  N_BIN  bitwise complement of datainbin
dataintherm  out  N_THERM  unary word; bit i drives cell i
datainthermb  out  N_THERM  bitwise complement of dataintherm
out_valid  out  1  outputs were updated this cycle
dwa_ptr  out  PTR_W  current DWA start pointer (debug/ATB)

Behaviour:
- Reset (rstb=0, asynchronous):
  - datainbin=0, dataintherm=0, datainbinb and datainthermb all ones.
  - out_valid=0, dwa_ptr=0, both pipeline stages invalid.
  - Release is synchronous to clkin.
- Pipeline, 2 cycles of latency:
  - Sample accepted at edge T when data_valid=1 and pdb=1.
  - Outputs change at edge T+2 with out_valid=1 for exactly that cycle.
  - Back-to-back samples run at full rate, one per cycle.
- Stage 1:
  - code = fmt_twos ? data_in with its MSB inverted : data_in.
  - k = code[N_BIN+N_MSB-1:N_BIN], range 0..N_THERM.
  - b = code[N_BIN-1:0].
- Stage 2, static mode (dwa_en=0):
  - Bits 0..k-1 of dataintherm are set, all others clear.
  - dwa_ptr is forced to 0.
- Stage 2, DWA mode (dwa_en=1):
  - Set cells ptr, ptr+1, ..., ptr+k-1, each index mod N_THERM.
  - Next ptr = (ptr+k) mod N_THERM. Since ptr+k < 2*N_THERM, one conditional subtraction suffices.
  - k=0 sets no cells and leaves ptr unchanged.
  - k=N_THERM sets all cells and leaves ptr unchanged.
- dwa_en sampling:
  - dwa_en is sampled in stage 2 together with its sample.
  - Toggling 1→0 zeroes ptr on the next valid sample.
  - Toggling 0→1 starts rotation from ptr=0.
- Hold behaviour: while no valid sample reaches stage 2, all outputs and dwa_ptr hold their last value and out_valid=0.
- Complements: datainbinb=~datainbin and datainthermb=~dataintherm. Both are registered in the same flops stage as the true buses, so the two buses are never skewed by a cycle.
- Power-down (pdb=0):
  - At the next edge, both stages are flushed invalid, outputs are parked at zero code (the reset values) and dwa_ptr=0.
  - Samples presented while pdb=0 are dropped.
  - After pdb returns to 1, the first output appears 2 cycles after the next accepted sample.
- Reset asserted mid-stream: in-flight samples are discarded with no partial output.

Decomposition:
- Package dac_seg_pkg holds:
  - the N_BIN/N_MSB defaults;
  - the function therm_mask(k, ptr, n), which returns the rotated unary vector;
  - the wrap-add function for the pointer.
- One sub-module, dac_dwa_rotator: registered pointer plus combinational mask.
- The top level holds format conversion, the pipeline and the output flops.

Test Plan:
- Reset and parking: assert rstb=0 mid-stream → datainbin=0, dataintherm=0, complements all ones, out_valid=0, dwa_ptr=0 asynchronously; first valid sample after release appears 2 cycles later.
- Static encode: dwa_en=0, fmt_twos=0, data_in=11'h5A3 (k=11, b=35) → after 2 cycles dataintherm=15'h07FF, datainthermb=15'h7800, datainbin=7'd35, datainbinb=7'd92.
- DWA wrap: dwa_en=1, two samples with k=10 → first dataintherm=15'h03FF with ptr→10; second sets cells 10..14 and 0..4, giving 15'h7C1F with ptr→5.
- Boundary codes in DWA: k=15 → dataintherm=15'h7FFF and ptr unchanged; k=0 → dataintherm=0 and ptr unchanged.
- Two's complement: fmt_twos=1, data_in=0 → k=8, b=0, dataintherm=15'h00FF; data_in=11'h400 (-1024) → all zeros.
- Power-down mid-stream and hold: drop pdb for 3 cycles while feeding valid samples → outputs parked at zero code, dwa_ptr=0, no out_valid while parked. After pdb=1, with data_valid gaps of 4 cycles, outputs hold their last values between samples.
